regfile_wport_arb: RTL and testbench

//   Arbitrates the single regfile write port between pipeline writeback (WB) and
//   a long-latency unit (LU: divider / slow load). Registers the granted write

---
 rtl/regfile_wport_arb.sv | 122 ++++++++++++
 tb/tb_regfile_wport_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arb.sv
// Single regfile write-port arbiter between pipeline writeback and a long-latency
// unit, with a registered write toward the regfile and a pending-write scoreboard.
module regfile_wport_arb #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_ready,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LU
  } gnt_e;

  gnt_e                gnt;
  logic                starved;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_nxt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIM));

  // WB wins contention until LU has lost STARVE_LIM times in a row.
  always_comb begin
    gnt = GNT_NONE;
    if (wb_valid && lu_valid) begin
      gnt = starved ? GNT_LU : GNT_WB;
    end else if (wb_valid) begin
      gnt = GNT_WB;
    end else if (lu_valid) begin
      gnt = GNT_LU;
    end
  end

  assign wb_ready = (gnt == GNT_WB);
  assign lu_ready = (gnt == GNT_LU);

  always_comb begin
    starve_nxt = '0;
    if (lu_valid && !lu_ready) begin
      starve_nxt = starved ? starve_cnt : starve_cnt + CNT_W'(1);
    end
  end

  // Clear first, then set, so a same-cycle issue to the retiring register wins.
  always_comb begin
    pending_nxt = pending;
    if (gnt == GNT_LU) begin
      pending_nxt[lu_waddr] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) begin
      pending_nxt[iss_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  assign stall_req = (re1 && pending[raddr_1])
                   || (re2 && pending[raddr_2])
                   || (iss_valid && pending[iss_addr]);

  always_comb begin
    sel_addr = wb_waddr;
    sel_data = wb_wdata;
    if (gnt == GNT_LU) begin
      sel_addr = lu_waddr;
      sel_data = lu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      pending    <= pending_nxt;
      if (gnt != GNT_NONE) begin
        rf_we    <= (sel_addr != '0);
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  // Issue to a pending register is only legal when that register retires this cycle.
  a_no_issue_to_pending: assert property (@(posedge clk) disable iff (!rst)
    !(iss_valid && (iss_addr != '0) && pending[iss_addr]
      && !((gnt == GNT_LU) && (lu_waddr == iss_addr))));

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed scenarios plus randomized traffic checked
// against a behavioural model of arbitration, output register and scoreboard.
module tb_regfile_wport_arb;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_ready;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic              lu_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              re1;
  logic [ADDR_W-1:0] raddr_1;
  logic              re2;
  logic [ADDR_W-1:0] raddr_2;
  logic              stall_req;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  regfile_wport_arb #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .wb_ready (wb_ready),
    .lu_valid (lu_valid),
    .lu_waddr (lu_waddr),
    .lu_wdata (lu_wdata),
    .lu_ready (lu_ready),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .re1      (re1),
    .raddr_1  (raddr_1),
    .re2      (re2),
    .raddr_2  (raddr_2),
    .stall_req(stall_req),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  bit                m_pend [NUM_REGS];
  int unsigned       m_losses;
  bit                m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                g_wb;
  bit                g_lu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_REGS); i++) m_pend[i] = 1'b0;
    m_losses = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    bit stall_exp;
    #1;
    g_wb = wb_valid && (!lu_valid || m_losses < STARVE_LIM);
    g_lu = lu_valid && !g_wb;
    stall_exp = (re1 && m_pend[raddr_1]) || (re2 && m_pend[raddr_2])
              || (iss_valid && m_pend[iss_addr]);
    chk("wb_ready", 32'(wb_ready), 32'(g_wb));
    chk("lu_ready", 32'(lu_ready), 32'(g_lu));
    chk("stall_req", 32'(stall_req), 32'(stall_exp));
    @(posedge clk);
    if (g_wb) begin
      m_we = (wb_waddr != 0); m_waddr = wb_waddr; m_wdata = wb_wdata;
    end else if (g_lu) begin
      m_we = (lu_waddr != 0); m_waddr = lu_waddr; m_wdata = lu_wdata;
    end else begin
      m_we = 1'b0;
    end
    if (lu_valid && !g_lu) m_losses = (m_losses >= STARVE_LIM) ? STARVE_LIM : m_losses + 1;
    else m_losses = 0;
    if (g_lu) m_pend[lu_waddr] = 1'b0;
    if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_waddr = '0; wb_wdata = '0;
    lu_valid = 0; lu_waddr = '0; lu_wdata = '0;
    iss_valid = 0; iss_addr = '0;
    re1 = 0; raddr_1 = '0; re2 = 0; raddr_2 = '0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // WB only
    wb_valid = 1; wb_waddr = 5'd3; wb_wdata = 32'h11;
    #1 chk("wbonly_ready", 32'(wb_ready), 32'd1);
    step();
    chk("wbonly_we", 32'(rf_we), 32'd1);
    chk("wbonly_data", rf_wdata, 32'h11);
    wb_valid = 0;
    step();
    chk("wbonly_we_drop", 32'(rf_we), 32'd0);

    // Contention: WB x4, LU, WB
    for (int i = 0; i < 6; i++) begin
      wb_valid = 1; wb_waddr = ADDR_W'(10 + i); wb_wdata = $urandom;
      lu_valid = 1; lu_waddr = 5'd20; lu_wdata = $urandom;
      #1 chk("contention_lu", 32'(lu_ready), 32'(i == 4));
      step();
    end
    idle_inputs();

    // LU to address 0
    lu_valid = 1; lu_waddr = '0; lu_wdata = 32'hFF;
    #1 chk("addr0_ready", 32'(lu_ready), 32'd1);
    step();
    chk("addr0_we", 32'(rf_we), 32'd0);
    idle_inputs();

    // Scoreboard on register 7
    iss_valid = 1; iss_addr = 5'd7;
    step();
    iss_valid = 0; re1 = 1; raddr_1 = 5'd7;
    step();
    #1 chk("sb_pending", 32'(stall_req), 32'd1);
    lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h77;
    #1 chk("sb_clear_cycle", 32'(stall_req), 32'd1);
    step();
    lu_valid = 0;
    #1 chk("sb_cleared", 32'(stall_req), 32'd0);
    iss_valid = 1; iss_addr = 5'd7;
    step();
    lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h78;
    step();
    idle_inputs();
    re1 = 1; raddr_1 = 5'd7;
    #1 chk("sb_set_wins", 32'(stall_req), 32'd1);
    step();

    // Async reset in the middle of contention
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_waddr = 5'd9; wb_wdata = 32'h9900 + 32'(i);
      lu_valid = 1; lu_waddr = 5'd21; lu_wdata = 32'h2100;
      step();
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_we", 32'(rf_we), 32'd0);
    chk("arst_waddr", 32'(rf_waddr), 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 chk("arst_held_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1; wb_waddr = ADDR_W'(1 + i); wb_wdata = $urandom;
      lu_valid = 1; lu_waddr = 5'd22; lu_wdata = $urandom;
      #1 chk("arst_starve_cleared", 32'(lu_ready), 32'(i == 4));
      step();
    end
    idle_inputs();

    // Randomized traffic; requesters hold until granted, issues avoid pending regs
    for (int n = 0; n < 600; n++) begin
      if (wb_valid && g_wb) wb_valid = 0;
      if (lu_valid && g_lu) lu_valid = 0;
      if (!wb_valid && $urandom_range(0, 3) != 0) begin
        wb_valid = 1; wb_waddr = ADDR_W'($urandom); wb_wdata = $urandom;
      end
      if (!lu_valid && $urandom_range(0, 1) != 0) begin
        lu_valid = 1; lu_waddr = ADDR_W'($urandom); lu_wdata = $urandom;
        if ($urandom_range(0, 1) != 0) begin
          for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (m_pend[(int'(lu_waddr) + k) % NUM_REGS]) begin
              lu_waddr = ADDR_W'((int'(lu_waddr) + k) % NUM_REGS);
              break;
            end
          end
        end
      end
      iss_addr  = ADDR_W'($urandom);
      iss_valid = ($urandom_range(0, 2) == 0) && !m_pend[iss_addr];
      re1 = 1'($urandom); raddr_1 = ADDR_W'($urandom);
      re2 = 1'($urandom); raddr_2 = ADDR_W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
